// File: rtl/qspi_apb_master.sv
// qspi_apb_master: turns a valid/ready request stream into single APB3/4
// transfers (SETUP then ACCESS), with wait states, PSLVERR capture and an
// optional bus timeout. Exactly one response is returned per request.
module qspi_apb_master #(
    parameter int ADDR_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 16,
    parameter bit HAS_PSTRB      = 1'b1
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]           req_wdata_i,
    input  logic [3:0]            req_strb_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,
    output logic                  busy_o,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [31:0]           pwdata,
    output logic [3:0]            pstrb,
    input  logic [31:0]           prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    // The abort fires on the ACCESS cycle where the wait counter reaches
    // TIMEOUT_CYCLES-1, i.e. on the TIMEOUT_CYCLES-th stalled ACCESS cycle.
    localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TMO_LAST = TMO_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

    state_t                  state_q, state_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [31:0]             pwdata_q, pwdata_d;
    logic [3:0]              pstrb_q, pstrb_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [31:0]             rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    rsp_timeout_q, rsp_timeout_d;
    logic [15:0]             tmo_cnt_q, tmo_cnt_d;

    // Next-state and registered-output decode; every field holds by default.
    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        tmo_cnt_d     = tmo_cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    pwrite_d = req_write_i;
                    paddr_d  = req_addr_i;
                    pwdata_d = req_wdata_i;
                    pstrb_d  = req_write_i ? (HAS_PSTRB ? req_strb_i : 4'hF) : 4'h0;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                tmo_cnt_d = 16'd0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? 32'd0 : prdata;
                    rsp_err_d     = pslverr;
                    rsp_timeout_d = 1'b0;
                    state_d       = RESP;
                end else if (TMO_EN && (tmo_cnt_q == TMO_LAST)) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = 32'd0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; async reset clears everything.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= 32'd0;
            pstrb_q       <= 4'd0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'd0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            tmo_cnt_q     <= 16'd0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            tmo_cnt_q     <= tmo_cnt_d;
        end
    end

    // req_ready_o is gated by presetn so it reads 0 while reset is held.
    assign req_ready_o   = presetn & (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);
    assign psel          = psel_q;
    assign penable       = penable_q;
    assign pwrite        = pwrite_q;
    assign paddr         = paddr_q;
    assign pwdata        = pwdata_q;
    assign pstrb         = pstrb_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_qspi_apb_master.sv
// Self-checking bench for qspi_apb_master: scripted APB slave, response
// scoreboard, bus protocol monitor and per-transfer cycle accounting.
module tb_qspi_apb_master;

    localparam int AW = 12;

    logic          pclk = 1'b0;
    logic          presetn = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic          req_write_i = 1'b0;
    logic [AW-1:0] req_addr_i = '0;
    logic [31:0]   req_wdata_i = 32'd0;
    logic [3:0]    req_strb_i = 4'd0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b1;
    logic [31:0]   rsp_rdata_o;
    logic          rsp_err_o;
    logic          rsp_timeout_o;
    logic          busy_o;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [31:0]   pwdata;
    logic [3:0]    pstrb;
    logic [31:0]   prdata;
    logic          pready;
    logic          pslverr;

    qspi_apb_master #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16), .HAS_PSTRB(1'b1)) dut (
        .pclk(pclk), .presetn(presetn),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_write_i(req_write_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .req_strb_i(req_strb_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .rsp_timeout_o(rsp_timeout_o), .busy_o(busy_o),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata),
        .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } rsp_t;

    rsp_t expQ[$];
    rsp_t expItem;
    int   checks = 0;
    int   failures = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Scripted slave: pready rises after waitCycles stalled ACCESS cycles.
    int          waitCycles = 0;
    int          accessCnt = 0;
    logic        stuck = 1'b0;
    logic        errFlag = 1'b0;
    logic [31:0] slvData = 32'd0;

    assign pready  = psel && penable && !stuck && (accessCnt >= waitCycles);
    assign prdata  = slvData;
    assign pslverr = errFlag && pready;

    always @(posedge pclk) begin
        if (!penable) accessCnt <= 0;
        else if (psel && !pready) accessCnt <= accessCnt + 1;
    end

    // Scoreboard: pop and compare whenever a response handshake is seen.
    always @(negedge pclk) begin
        if (presetn && rsp_valid_o && rsp_ready_i) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedRsp", 32'd1, 32'd0);
            end else begin
                expItem = expQ.pop_front();
                checkOutput("rspRdata", rsp_rdata_o, expItem.rdata);
                checkOutput("rspErr", 32'(rsp_err_o), 32'(expItem.err));
                checkOutput("rspTimeout", 32'(rsp_timeout_o), 32'(expItem.tmo));
            end
        end
    end

    // Protocol monitor: penable without psel, back-to-back select, unstable bus.
    int          protoErr = 0;
    logic        prevPsel = 1'b0;
    logic [AW-1:0] prevAddr = '0;
    logic [31:0] prevWdata = 32'd0;
    always @(negedge pclk) begin
        if (penable && !psel) protoErr++;
        if (psel && !penable && prevPsel) protoErr++;
        if (psel && penable && prevPsel && (paddr != prevAddr || pwdata != prevWdata)) protoErr++;
        prevPsel  = psel;
        prevAddr  = paddr;
        prevWdata = pwdata;
    end

    int            lat, pselCyc, penCyc;
    logic [AW-1:0] lastAddr;
    logic [31:0]   lastWdata;
    logic [3:0]    lastStrb;
    logic          lastWrite;

    // Follows one transfer from just after its accept edge until rsp_valid_o.
    task automatic waitResponse();
        lat = 0; pselCyc = 0; penCyc = 0;
        do begin
            @(negedge pclk);
            lat++;
            if (psel) pselCyc++;
            if (penable) penCyc++;
            if (psel && !penable) begin
                lastAddr = paddr; lastWdata = pwdata; lastStrb = pstrb; lastWrite = pwrite;
            end
        end while (!rsp_valid_o && lat < 100);
        checkOutput("rspBound", 32'(rsp_valid_o), 32'd1);
        if (rsp_ready_i) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] strb, input logic [31:0] expRdata,
                                 input logic expErr, input logic expTmo);
        int n;
        rsp_t e;
        e.rdata = expRdata; e.err = expErr; e.tmo = expTmo;
        expQ.push_back(e);
        req_write_i = wr; req_addr_i = addr; req_wdata_i = wdata; req_strb_i = strb;
        req_valid_i = 1'b1;
        n = 0;
        @(negedge pclk);
        while (!req_ready_o && n < 20) begin
            @(negedge pclk);
            n++;
        end
        checkOutput("acceptBound", 32'(req_ready_o), 32'd1);
        @(posedge pclk);
        #1 req_valid_i = 1'b0;
        waitResponse();
    endtask

    initial begin
        // Reset state
        #12;
        checkOutput("rstPsel", 32'(psel), 32'd0);
        checkOutput("rstPenable", 32'(penable), 32'd0);
        checkOutput("rstRspValid", 32'(rsp_valid_o), 32'd0);
        checkOutput("rstReqReady", 32'(req_ready_o), 32'd0);
        checkOutput("rstBusy", 32'(busy_o), 32'd0);
        checkOutput("rstPaddr", 32'(paddr), 32'd0);
        checkOutput("rstPstrb", 32'(pstrb), 32'd0);
        @(posedge pclk);
        #1 presetn = 1'b1;
        @(negedge pclk);
        checkOutput("idleReqReady", 32'(req_ready_o), 32'd1);
        @(posedge pclk);
        #1;

        // 1: zero-wait write
        slvData = 32'hDEAD_BEEF;
        applyStimulus(1'b1, 12'h004, 32'h0000_0301, 4'hF, 32'd0, 1'b0, 1'b0);
        checkOutput("t1Latency", 32'(lat), 32'd3);
        checkOutput("t1PselCyc", 32'(pselCyc), 32'd2);
        checkOutput("t1PenCyc", 32'(penCyc), 32'd1);
        checkOutput("t1Pwdata", lastWdata, 32'h0000_0301);
        checkOutput("t1Paddr", 32'(lastAddr), 32'h004);
        checkOutput("t1Pstrb", 32'(lastStrb), 32'hF);
        checkOutput("t1Pwrite", 32'(lastWrite), 32'd1);

        // 2: zero-wait read
        slvData = 32'h1A00_1081;
        applyStimulus(1'b0, 12'h000, 32'hFFFF_FFFF, 4'hF, 32'h1A00_1081, 1'b0, 1'b0);
        checkOutput("t2Pstrb", 32'(lastStrb), 32'h0);
        checkOutput("t2Pwrite", 32'(lastWrite), 32'd0);
        checkOutput("t2Latency", 32'(lat), 32'd3);

        // 3: read with three wait states
        waitCycles = 3; slvData = 32'h0000_5A5A;
        applyStimulus(1'b0, 12'h02C, 32'd0, 4'h0, 32'h0000_5A5A, 1'b0, 1'b0);
        checkOutput("t3PenCyc", 32'(penCyc), 32'd4);
        checkOutput("t3Latency", 32'(lat), 32'd6);
        checkOutput("t3Paddr", 32'(lastAddr), 32'h02C);
        waitCycles = 0;

        // 4a: slave error on write
        errFlag = 1'b1;
        applyStimulus(1'b1, 12'h008, 32'h0000_00A5, 4'h5, 32'd0, 1'b1, 1'b0);
        checkOutput("t4Pstrb", 32'(lastStrb), 32'h5);
        errFlag = 1'b0;

        // 4b: stuck slave aborts after 16 ACCESS cycles
        stuck = 1'b1; slvData = 32'h1234_5678;
        applyStimulus(1'b0, 12'h010, 32'd0, 4'h0, 32'd0, 1'b1, 1'b1);
        checkOutput("t4TmoPenCyc", 32'(penCyc), 32'd16);
        checkOutput("t4TmoLatency", 32'(lat), 32'd18);
        stuck = 1'b0;

        // 4c: pready on the 16th ACCESS cycle wins over the timeout
        waitCycles = 15;
        applyStimulus(1'b0, 12'h010, 32'd0, 4'h0, 32'h1234_5678, 1'b0, 1'b0);
        checkOutput("t4EdgePenCyc", 32'(penCyc), 32'd16);
        waitCycles = 0;

        // Write with all strobes off is still issued
        applyStimulus(1'b1, 12'h01C, 32'h0000_0077, 4'h0, 32'd0, 1'b0, 1'b0);
        checkOutput("zeroStrbPsel", 32'(pselCyc), 32'd2);
        checkOutput("zeroStrbPstrb", 32'(lastStrb), 32'h0);

        // 5: response backpressure with a queued follow-up request
        slvData = 32'hCAFE_0001;
        rsp_ready_i = 1'b0;
        expItem.rdata = 32'hCAFE_0001; expItem.err = 1'b0; expItem.tmo = 1'b0;
        expQ.push_back(expItem);
        req_write_i = 1'b0; req_addr_i = 12'h014; req_valid_i = 1'b1;
        @(posedge pclk);
        #1;
        expItem.rdata = 32'd0; expItem.err = 1'b0; expItem.tmo = 1'b0;
        expQ.push_back(expItem);
        req_write_i = 1'b1; req_addr_i = 12'h018; req_wdata_i = 32'h0000_0042; req_strb_i = 4'h3;
        repeat (3) @(negedge pclk);
        checkOutput("t5RspRise", 32'(rsp_valid_o), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            checkOutput("t5HoldValid", 32'(rsp_valid_o), 32'd1);
            checkOutput("t5HoldRdata", rsp_rdata_o, 32'hCAFE_0001);
            checkOutput("t5HoldReqReady", 32'(req_ready_o), 32'd0);
            checkOutput("t5HoldPsel", 32'(psel), 32'd0);
        end
        @(posedge pclk);
        #1 rsp_ready_i = 1'b1;
        @(posedge pclk);
        #1;
        @(negedge pclk);
        checkOutput("t5IdleReady", 32'(req_ready_o), 32'd1);
        @(posedge pclk);
        #1 req_valid_i = 1'b0;
        @(negedge pclk);
        checkOutput("t5NewPsel", 32'(psel), 32'd1);
        checkOutput("t5NewPaddr", 32'(paddr), 32'h018);
        checkOutput("t5NewPstrb", 32'(pstrb), 32'h3);
        waitResponse();

        // 6: asynchronous reset during an ACCESS wait
        stuck = 1'b1;
        req_write_i = 1'b0; req_addr_i = 12'h020; req_valid_i = 1'b1;
        @(posedge pclk);
        #1 req_valid_i = 1'b0;
        repeat (4) @(negedge pclk);
        checkOutput("t6InAccess", 32'(penable), 32'd1);
        #2 presetn = 1'b0;
        #1;
        checkOutput("t6RstPsel", 32'(psel), 32'd0);
        checkOutput("t6RstPenable", 32'(penable), 32'd0);
        checkOutput("t6RstRspValid", 32'(rsp_valid_o), 32'd0);
        checkOutput("t6RstReqReady", 32'(req_ready_o), 32'd0);
        stuck = 1'b0;
        @(posedge pclk);
        #1 presetn = 1'b1;
        @(negedge pclk);
        checkOutput("t6RelReqReady", 32'(req_ready_o), 32'd1);
        checkOutput("t6RelBusy", 32'(busy_o), 32'd0);
        repeat (3) @(negedge pclk);
        checkOutput("t6NoStaleRsp", 32'(rsp_valid_o), 32'd0);
        @(posedge pclk);
        #1;
        slvData = 32'h0BAD_F00D;
        applyStimulus(1'b0, 12'h024, 32'd0, 4'h0, 32'h0BAD_F00D, 1'b0, 1'b0);

        repeat (2) @(negedge pclk);
        checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
        checkOutput("protocol", 32'(protoErr), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qspi_apb_master.md
Name: qspi_apb_master

Overview:
APB3/4 initiator that turns a simple valid/ready request stream into single APB transfers toward the QSPI controller CSR slave, or any other APB target. Used by the boot-time flash init sequencer and by the debug bridge to program CTRL, CMD_*, XIP_* and to poll STATUS. Handles wait states, PSLVERR and a bus timeout. Returns one response per request over a valid/ready channel.

Parameters:
ADDR_WIDTH, 12, width of paddr and req_addr_i
TIMEOUT_CYCLES, 16, maximum ACCESS cycles with pready=0 before abort; 0 disables the timeout; legal range 0..65535
HAS_PSTRB, 1, 1: drive pstrb from the request; 0: drive 4'b1111 on writes

Ports:
pclk  in  1  clock
presetn  in  1  async active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
req_write_i  in  1  1=write, 0=read
req_addr_i  in  ADDR_WIDTH  target address
req_wdata_i  in  32  write data
req_strb_i  in  4  byte strobes for writes
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when valid&ready
rsp_rdata_o  out  32  read data; 0 for writes
rsp_err_o  out  1  pslverr seen or timeout
rsp_timeout_o  out  1  transfer aborted by timeout
busy_o  out  1  state != IDLE
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_WIDTH  APB address
pwdata  out  32  APB write data
pstrb  out  4  APB strobes
prdata  in  32  APB read data
pready  in  1  APB ready
pslverr  in  1  APB error

Behaviour:
- Reset: presetn is asynchronous and active-low; pclk is the clock. Reset forces state IDLE and drives all outputs to 0: psel, penable, pwrite, paddr, pwdata, pstrb, rsp_*, busy_o. req_ready_o also reads 0 during reset. When reset asserts mid-transfer, psel and penable drop immediately and no response is produced.
- FSM states are IDLE, SETUP, ACCESS and RESP. All outputs are registered except req_ready_o and busy_o, which decode the state.
- IDLE: req_ready_o=1. On req_valid_i, capture write, addr, wdata and strb, then go to SETUP. The request is taken on this edge.
- SETUP: exactly one cycle with psel=1 and penable=0. Then go to ACCESS.
- ACCESS: psel=1 and penable=1. paddr, pwrite, pwdata and pstrb stay stable from SETUP until the transfer ends.
  - pready=1 ends the transfer. rsp_rdata_o takes prdata on reads and 0 on writes. rsp_err_o takes pslverr, rsp_timeout_o is 0, psel and penable drop, and the FSM goes to RESP.
  - Timeout: a 16-bit counter clears on SETUP and increments on each ACCESS cycle with pready=0. If TIMEOUT_CYCLES!=0 and the counter equals TIMEOUT_CYCLES-1 while pready=0, the transfer aborts: psel and penable drop, rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0, and the FSM goes to RESP.
  - When pready=1 arrives on the abort cycle, pready wins and no timeout is reported.
- RESP: rsp_valid_o=1 and the response fields hold stable. When rsp_ready_i=1, rsp_valid_o clears and the FSM returns to IDLE. req_ready_o stays 0 throughout RESP.
- Latency with a zero-wait slave: accept at edge N, SETUP in cycle N+1, ACCESS in N+2, rsp_valid_o high from N+3. Throughput is at most one transfer per 4 cycles when rsp_ready_i is held at 1.
- Strobes:
  - Writes: pstrb = req_strb_i if HAS_PSTRB=1, else 4'b1111.
  - Reads: pstrb = 0.
  - Writes with req_strb_i=0 are still issued.
- Bus hold values:
  - Outside SETUP and ACCESS, psel=0 and penable=0.
  - paddr, pwrite, pwdata and pstrb hold their last values. No requirement is placed on them while psel=0.
- penable is never 1 while psel=0. psel is never asserted for two transfers without a deasserted cycle between them.
- pready and pslverr are sampled only in ACCESS. prdata is ignored on writes.

Test Plan:
1. Write 0x0000_0301 to 0x004 with strb 4'hF against a zero-wait slave -> psel high for 2 cycles, penable in the second only; pwdata=0x301; response at N+3 with rsp_err_o=0 and rsp_rdata_o=0.
2. Read 0x000 while the slave returns 0x1A00_1081 -> rsp_rdata_o=0x1A00_1081, rsp_err_o=0, pstrb=0 during the transfer.
3. Read 0x02C with pready low for 3 ACCESS cycles -> ACCESS lasts 4 cycles, address stays stable, rsp_valid_o rises the cycle after pready.
4. Write to 0x008 while the slave asserts pslverr -> rsp_err_o=1, rsp_timeout_o=0; then TIMEOUT_CYCLES=16 with pready stuck at 0 -> abort after 16 ACCESS cycles, rsp_err_o=1, rsp_timeout_o=1; pready=1 on cycle 16 -> normal completion.
5. Hold rsp_ready_i=0 for 5 cycles with req_valid_i=1 -> response held stable, req_ready_o=0, no new psel; on release a new transfer is accepted the next cycle.
6. Assert presetn=0 in the middle of an ACCESS wait -> psel, penable and rsp_valid_o go to 0 asynchronously; after release the FSM is in IDLE with req_ready_o=1 and no stale response.
